// File: rtl/imem_arbiter_pkg.sv
// rtl/imem_arbiter_pkg.sv - shared types and constants for the instruction-memory arbiter
//
// Purpose: core count, core id type, default stall-counter width and a
//          helper that turns a one-hot grant into a core id.
// Ports:   none (package).
package imem_arb_pkg;

  localparam int NUM_CORES = 2;
  localparam int DEF_CNT_W = 16;

  typedef logic core_id_t;

  // Grant is at most one-hot across two cores, so bit 1 alone names the winner.
  function automatic core_id_t gnt_to_id(input logic [NUM_CORES-1:0] g);
    return core_id_t'(g[1]);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch/response/memory bus between two cores and the arbiter
//
// Purpose: bundles the per-core fetch request, the response strobes and the
//          instruction-memory read port.
// Ports:   master = cores + memory side (drives req/pc/flush/mem_instr),
//          slave  = arbiter side (drives gnt/rsp_valid/rsp_instr/mem_en/mem_pc).
interface imem_arbiter_if #(
  parameter int PC_W = 32
);
  import imem_arb_pkg::*;

  logic [NUM_CORES-1:0]           req;
  logic [NUM_CORES-1:0][PC_W-1:0] pc;
  logic [NUM_CORES-1:0]           flush;
  logic [NUM_CORES-1:0]           gnt;
  logic [NUM_CORES-1:0]           rsp_valid;
  logic [31:0]                    rsp_instr;
  logic                           mem_en;
  logic [PC_W-1:0]                mem_pc;
  logic [31:0]                    mem_instr;

  modport master (
    output req, pc, flush, mem_instr,
    input  gnt, rsp_valid, rsp_instr, mem_en, mem_pc
  );

  modport slave (
    input  req, pc, flush, mem_instr,
    output gnt, rsp_valid, rsp_instr, mem_en, mem_pc
  );

endinterface

// File: rtl/imem_arbiter_rr_arb2.sv
// rtl/imem_arbiter_rr_arb2.sv - two-way round-robin grant with last-winner pointer
//
// Purpose: combinational grant from the effective request vector; on a tie the
//          core that did not win last time is chosen.
// Ports:   clk, rst    - clock, synchronous active-high reset
//          eff  [1:0]  - effective requests (already masked by flush/reset)
//          gnt  [1:0]  - combinational grant, at most one bit set
module rr_arb2
  import imem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] eff,
  output logic [NUM_CORES-1:0] gnt
);

  core_id_t last_gnt;

  always_comb begin
    gnt = '0;
    case (eff)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Tie: the core that did not win last time gets it.
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  // Reset value 1 makes core 0 the winner of the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (|gnt) begin
      last_gnt <= gnt_to_id(gnt);
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - shares one instruction memory between two fetch units
//
// Purpose: round-robin fetch arbitration, one-cycle read-response routing,
//          per-core flush of requests/responses and saturating stall counters.
// Ports:   clk, rst   - clock, synchronous active-high reset
//          bus        - imem_arbiter_if slave: req/pc/flush in, gnt/rsp_valid/
//                       rsp_instr out, mem_en/mem_pc out, mem_instr in
//          stall_clr  - zero both stall counters next cycle
//          stall_cnt  - per-core cycles requested but not granted
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  imem_arbiter_if.slave                   bus,
  input  logic                            stall_clr,
  output logic [NUM_CORES-1:0][CNT_W-1:0] stall_cnt
);

  logic [NUM_CORES-1:0] eff;
  logic [NUM_CORES-1:0] gnt;
  logic [PC_W-1:0]      sel_pc;
  logic                 if_valid;
  core_id_t             if_id;

  // Reset masks requests so gnt/mem_en drop in the reset cycle itself.
  assign eff = bus.req & ~bus.flush & {NUM_CORES{~rst}};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .eff (eff),
    .gnt (gnt)
  );

  always_comb begin
    sel_pc = '0;
    if (gnt[0]) begin
      sel_pc = bus.pc[0];
    end else if (gnt[1]) begin
      sel_pc = bus.pc[1];
    end
  end

  assign bus.gnt       = gnt;
  assign bus.mem_en    = |gnt;
  assign bus.mem_pc    = sel_pc;
  assign bus.rsp_instr = bus.mem_instr;

  // One read in flight at most: it is whatever was granted last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_id    <= 1'b0;
    end else begin
      if_valid <= |gnt;
      if_id    <= gnt_to_id(gnt);
    end
  end

  // A flush in the response cycle kills that core's strobe; so does reset,
  // which discards a read issued just before it.
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      bus.rsp_valid[i] = if_valid & (if_id == core_id_t'(i)) & ~bus.flush[i] & ~rst;
    end
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (rst || stall_clr) begin
        stall_cnt[i] <= '0;
      end else if (eff[i] && !gnt[i] && !(&stall_cnt[i])) begin
        stall_cnt[i] <= stall_cnt[i] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;

  localparam logic [31:0] K = 32'hA5C3_0000;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  flush;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        clr;
    logic [1:0]  gnt;
    logic [31:0] mem_pc;
    logic [1:0]  rsp;
    logic [3:0]  s0;
    logic [3:0]  s1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic stall_clr;
  logic [1:0][3:0] stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  imem_arbiter_if #(.PC_W(32)) bus ();

  imem_arbiter #(.PC_W(32), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory: data is a tagged copy of the address.
  always @(posedge clk) begin
    bus.mem_instr <= bus.mem_en ? (bus.mem_pc ^ K) : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] fl,
                       input logic [31:0] p0, input logic [31:0] p1, input logic c);
    @(negedge clk);
    rst       = r;
    bus.req   = rq;
    bus.flush = fl;
    bus.pc[0] = p0;
    bus.pc[1] = p1;
    stall_clr = c;
    #2;
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] fl,
                              input logic [31:0] p0, input logic [31:0] p1, input logic c,
                              input logic [1:0] g, input logic [31:0] mp, input logic [1:0] rs,
                              input logic [3:0] e0, input logic [3:0] e1);
    vec_t v;
    v.rst = r; v.req = rq; v.flush = fl; v.pc0 = p0; v.pc1 = p1; v.clr = c;
    v.gnt = g; v.mem_pc = mp; v.rsp = rs; v.s0 = e0; v.s1 = e1;
    return v;
  endfunction

  vec_t        tv[$];
  logic [31:0] prev_pc;
  logic        m_last;
  logic [3:0]  m_s0, m_s1;
  logic [1:0]  m_gnt;

  initial begin
    rst = 1'b1; stall_clr = 1'b0;
    bus.req = '0; bus.flush = '0; bus.pc[0] = '0; bus.pc[1] = '0;
    @(posedge clk);

    //          rst req    flush  pc0     pc1     clr   gnt    mem_pc  rsp    s0 s1
    tv.push_back(mk(1, 2'b11, 2'b00, 32'h0,  32'h20, 0,   2'b00, 32'h0,  2'b00, 0, 0));
    tv.push_back(mk(0, 2'b01, 2'b00, 32'h0,  32'h20, 0,   2'b01, 32'h0,  2'b00, 0, 0));
    tv.push_back(mk(0, 2'b01, 2'b00, 32'h0,  32'h20, 0,   2'b01, 32'h0,  2'b01, 0, 0));
    tv.push_back(mk(0, 2'b01, 2'b00, 32'h0,  32'h20, 0,   2'b01, 32'h0,  2'b01, 0, 0));
    tv.push_back(mk(0, 2'b00, 2'b00, 32'h0,  32'h20, 0,   2'b00, 32'h0,  2'b01, 0, 0));
    tv.push_back(mk(1, 2'b00, 2'b00, 32'h0,  32'h20, 0,   2'b00, 32'h0,  2'b00, 0, 0));
    tv.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0,   2'b01, 32'h10, 2'b00, 0, 0));
    tv.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0,   2'b10, 32'h20, 2'b01, 0, 1));
    tv.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0,   2'b01, 32'h10, 2'b10, 1, 1));
    tv.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0,   2'b10, 32'h20, 2'b01, 1, 2));
    tv.push_back(mk(0, 2'b10, 2'b00, 32'h10, 32'h30, 0,   2'b10, 32'h30, 2'b10, 2, 2));
    tv.push_back(mk(0, 2'b00, 2'b10, 32'h10, 32'h30, 0,   2'b00, 32'h0,  2'b00, 2, 2));
    tv.push_back(mk(0, 2'b10, 2'b10, 32'h10, 32'h30, 0,   2'b00, 32'h0,  2'b00, 2, 2));
    tv.push_back(mk(0, 2'b00, 2'b00, 32'h10, 32'h30, 0,   2'b00, 32'h0,  2'b00, 2, 2));
    tv.push_back(mk(0, 2'b01, 2'b00, 32'h10, 32'h30, 1,   2'b01, 32'h10, 2'b00, 2, 2));
    tv.push_back(mk(0, 2'b00, 2'b00, 32'h10, 32'h30, 0,   2'b00, 32'h0,  2'b01, 0, 0));

    prev_pc = 32'h0;
    foreach (tv[k]) begin
      drive(tv[k].rst, tv[k].req, tv[k].flush, tv[k].pc0, tv[k].pc1, tv[k].clr);
      chk($sformatf("v%0d gnt", k),       32'(bus.gnt),       32'(tv[k].gnt));
      chk($sformatf("v%0d mem_en", k),    32'(bus.mem_en),    32'(|tv[k].gnt));
      chk($sformatf("v%0d mem_pc", k),    bus.mem_pc,         tv[k].mem_pc);
      chk($sformatf("v%0d rsp_valid", k), 32'(bus.rsp_valid), 32'(tv[k].rsp));
      chk($sformatf("v%0d stall0", k),    32'(stall_cnt[0]),  32'(tv[k].s0));
      chk($sformatf("v%0d stall1", k),    32'(stall_cnt[1]),  32'(tv[k].s1));
      if (tv[k].rsp != 2'b00) begin
        chk($sformatf("v%0d rsp_instr", k), bus.rsp_instr, prev_pc ^ K);
      end
      prev_pc = tv[k].mem_pc;
    end

    // Sustained contention: each core loses 20 times, counters must stick at 15.
    m_last = 1'b0; m_s0 = 4'd0; m_s1 = 4'd0;
    for (int c = 0; c < 40; c++) begin
      drive(0, 2'b11, 2'b00, 32'h100, 32'h200, 0);
      m_gnt = m_last ? 2'b01 : 2'b10;
      chk($sformatf("sat%0d gnt", c),    32'(bus.gnt),      32'(m_gnt));
      chk($sformatf("sat%0d stall0", c), 32'(stall_cnt[0]), 32'(m_s0));
      chk($sformatf("sat%0d stall1", c), 32'(stall_cnt[1]), 32'(m_s1));
      if (m_gnt == 2'b01) begin
        if (m_s1 != 4'hF) m_s1 = m_s1 + 4'd1;
        m_last = 1'b0;
      end else begin
        if (m_s0 != 4'hF) m_s0 = m_s0 + 4'd1;
        m_last = 1'b1;
      end
    end
    chk("sat final s0", 32'(m_s0), 32'd15);
    // Clear coinciding with an increment.
    drive(0, 2'b11, 2'b00, 32'h100, 32'h200, 1);
    chk("clr pre s0", 32'(stall_cnt[0]), 32'd15);
    chk("clr pre s1", 32'(stall_cnt[1]), 32'd15);
    drive(0, 2'b00, 2'b00, 32'h100, 32'h200, 0);
    chk("clr post s0", 32'(stall_cnt[0]), 32'd0);
    chk("clr post s1", 32'(stall_cnt[1]), 32'd0);

    // Reset right after a grant discards the response; first tie goes to core 0.
    drive(0, 2'b01, 2'b00, 32'h40, 32'h50, 0);
    chk("rstflight gnt", 32'(bus.gnt), 32'd1);
    drive(1, 2'b11, 2'b00, 32'h40, 32'h50, 0);
    chk("rstflight rst gnt", 32'(bus.gnt), 32'd0);
    chk("rstflight rst mem_en", 32'(bus.mem_en), 32'd0);
    chk("rstflight rst mem_pc", bus.mem_pc, 32'd0);
    chk("rstflight rst rsp", 32'(bus.rsp_valid), 32'd0);
    drive(0, 2'b11, 2'b00, 32'h40, 32'h50, 0);
    chk("rstflight after rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rstflight first tie", 32'(bus.gnt), 32'd1);
    chk("rstflight tie mem_pc", bus.mem_pc, 32'h40);
    drive(0, 2'b00, 2'b00, 32'h40, 32'h50, 0);
    chk("rstflight rsp", 32'(bus.rsp_valid), 32'd1);
    chk("rstflight instr", bus.rsp_instr, 32'h40 ^ K);
    chk("rstflight stall1", 32'(stall_cnt[1]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
